// File: rtl/multicycle_control.sv
// Multicycle control sequencer: fetch, decode, execute, memory access and write-back
// over several cycles sharing one ALU, one register file and one memory port.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [31:0] instruction_i,
    input  logic [3:0]  nzcv_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_write_o,
    output logic        adr_src_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        reg_write_o,
    output logic        link_o,
    output logic [1:0]  result_src_o,
    output logic        alu_src_b_o,
    output logic [3:0]  flags_o,
    output logic        instr_done_o,
    output logic        undef_o,
    output logic        timeout_o
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_ALU_WB, S_MEM_ADDR,
        S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH
    } state_t;

    localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_WAIT_MAX);

    state_t        state, state_next;
    logic [3:0]    flags_q;
    logic [CW-1:0] wait_cnt;

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic       imm, s_bit, mem_l, br_l;

    assign cond  = instruction_i[31:28];
    assign op    = instruction_i[27:26];
    assign imm   = instruction_i[25];
    assign cmd   = instruction_i[24:21];
    assign s_bit = instruction_i[20];
    assign mem_l = instruction_i[20];
    assign br_l  = instruction_i[24];
    assign rd    = instruction_i[15:12];

    logic unused_fields;
    assign unused_fields = ^{instruction_i[19:16], instruction_i[11:0]};

    // Flags are packed N,Z,C,V from bit 3 down to bit 0.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return cy;
            4'b0011: return !cy;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return cy && !z;
            4'b1001: return !cy || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, pc_src;
    logic       reg_write, link, alu_src_b, instr_done, undef, timeout;
    logic       flags_we, mem_state, timeout_hit, alu_writes;
    logic [1:0] result_src;

    assign mem_state   = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign timeout_hit = mem_state && (wait_cnt == WAIT_LIMIT);
    assign alu_writes  = (cmd[3:2] != 2'b10);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state    <= S_FETCH;
            flags_q  <= 4'b0000;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (flags_we)
                flags_q <= nzcv_i;
            if (state_next != state || timeout_hit)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready_i)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Memory handshake: mem_req_o (with adr_src_o/mem_write_o) is held steady until the
    // cycle mem_ready_i is seen; ready outside a request is ignored; on timeout the
    // request drops for one cycle and the sequencer restarts at FETCH.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        link       = 1'b0;
        result_src = 2'b00;
        alu_src_b  = 1'b0;
        instr_done = 1'b0;
        undef      = 1'b0;
        timeout    = 1'b0;
        flags_we   = 1'b0;
        case (state)
            S_FETCH: begin
                if (timeout_hit) begin
                    timeout    = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready_i) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (!cond_pass(cond, flags_q)) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    case (op)
                        2'b00: state_next = S_EXECUTE;
                        2'b01: state_next = S_MEM_ADDR;
                        2'b10: state_next = S_BRANCH;
                        default: begin
                            undef      = 1'b1;
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end
            end
            S_EXECUTE: begin
                alu_src_b  = imm;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                if (alu_writes && rd == 4'd15) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end else begin
                    reg_write = alu_writes;
                end
                flags_we   = s_bit;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_b  = 1'b1;
                state_next = mem_l ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                if (timeout_hit) begin
                    timeout    = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready_i)
                        state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                if (timeout_hit) begin
                    timeout    = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready_i) begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_BRANCH: begin
                pc_write  = 1'b1;
                pc_src    = 1'b1;
                alu_src_b = 1'b1;
                if (br_l) begin
                    reg_write  = 1'b1;
                    link       = 1'b1;
                    result_src = 2'b10;
                end
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Every output is forced low for as long as reset is held.
    assign mem_req_o    = !reset_i && mem_req;
    assign mem_write_o  = !reset_i && mem_write;
    assign adr_src_o    = !reset_i && adr_src;
    assign ir_write_o   = !reset_i && ir_write;
    assign pc_write_o   = !reset_i && pc_write;
    assign pc_src_o     = !reset_i && pc_src;
    assign reg_write_o  = !reset_i && reg_write;
    assign link_o       = !reset_i && link;
    assign result_src_o = reset_i ? 2'b00 : result_src;
    assign alu_src_b_o  = !reset_i && alu_src_b;
    assign flags_o      = reset_i ? 4'b0000 : flags_q;
    assign instr_done_o = !reset_i && instr_done;
    assign undef_o      = !reset_i && undef;
    assign timeout_o    = !reset_i && timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors go into a
// scoreboard queue, and a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

    localparam int W = 18;

    // Output vector bit positions.
    localparam logic [W-1:0] REQ    = 18'h20000;
    localparam logic [W-1:0] WR     = 18'h10000;
    localparam logic [W-1:0] ADR    = 18'h08000;
    localparam logic [W-1:0] IRW    = 18'h04000;
    localparam logic [W-1:0] PCW    = 18'h02000;
    localparam logic [W-1:0] PCS    = 18'h01000;
    localparam logic [W-1:0] RW     = 18'h00800;
    localparam logic [W-1:0] LNK    = 18'h00400;
    localparam logic [W-1:0] RS_PC  = 18'h00200;
    localparam logic [W-1:0] RS_MEM = 18'h00100;
    localparam logic [W-1:0] ASB    = 18'h00080;
    localparam logic [W-1:0] DONE   = 18'h00004;
    localparam logic [W-1:0] UND    = 18'h00002;
    localparam logic [W-1:0] TO     = 18'h00001;
    localparam logic [W-1:0] FET    = REQ | IRW | PCW;
    localparam logic [W-1:0] NONE   = 18'h00000;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] instruction_i = 32'h0;
    logic [3:0]  nzcv_i = 4'h0;
    logic        mem_ready_i = 1'b0;
    logic        mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, pc_src_o;
    logic        reg_write_o, link_o, alu_src_b_o, instr_done_o, undef_o, timeout_o;
    logic [1:0]  result_src_o;
    logic [3:0]  flags_o;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    logic [3:0]   ef = 4'h0;
    int           checks = 0;
    int           passed = 0;

    multicycle_control #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .reset_i(reset_i), .instruction_i(instruction_i), .nzcv_i(nzcv_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
        .adr_src_o(adr_src_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .pc_src_o(pc_src_o), .reg_write_o(reg_write_o), .link_o(link_o),
        .result_src_o(result_src_o), .alu_src_b_o(alu_src_b_o), .flags_o(flags_o),
        .instr_done_o(instr_done_o), .undef_o(undef_o), .timeout_o(timeout_o)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    function automatic logic [W-1:0] o(input logic [W-1:0] b);
        return b | {11'b0, ef, 3'b0};
    endfunction

    task automatic step(input logic rst, input logic rdy, input logic [W-1:0] exp, input string tag);
        reset_i     = rst;
        mem_ready_i = rdy;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        step(1'b0, 1'b1, o(FET), tag);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] act, exp;
        string        tag;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            act = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, pc_src_o,
                   reg_write_o, link_o, result_src_o, alu_src_b_o, flags_o,
                   instr_done_o, undef_o, timeout_o};
            checks++;
            if (act !== exp)
                $display("FAIL %s: actual=%05h expected=%05h", tag, act, exp);
            else
                passed++;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, NONE, "reset0");
        step(1'b1, 1'b1, NONE, "reset1");

        instruction_i = 32'hE0821003;  // ADD R1,R2,R3
        fetch("add_fetch");
        step(1'b0, 1'b1, o(NONE), "add_decode");
        step(1'b0, 1'b1, o(NONE), "add_exec");
        step(1'b0, 1'b1, o(RW | DONE), "add_wb");

        instruction_i = 32'hE1510002;  // CMP R1,R2
        nzcv_i = 4'b0100;
        fetch("cmp_fetch");
        step(1'b0, 1'b1, o(NONE), "cmp_decode");
        step(1'b0, 1'b1, o(NONE), "cmp_exec");
        step(1'b0, 1'b1, o(DONE), "cmp_wb");
        ef = 4'b0100;

        instruction_i = 32'h0A000000;  // BEQ, Z set
        fetch("beq_fetch");
        step(1'b0, 1'b1, o(NONE), "beq_decode");
        step(1'b0, 1'b1, o(PCW | PCS | ASB | DONE), "beq_taken");

        instruction_i = 32'hE0921003;  // ADDS, clears flags
        nzcv_i = 4'b0000;
        fetch("adds0_fetch");
        step(1'b0, 1'b1, o(NONE), "adds0_decode");
        step(1'b0, 1'b1, o(NONE), "adds0_exec");
        step(1'b0, 1'b1, o(RW | DONE), "adds0_wb");
        ef = 4'b0000;

        instruction_i = 32'h0A000000;  // BEQ, Z clear: skipped
        fetch("beq_skip_fetch");
        step(1'b0, 1'b1, o(DONE), "beq_skip");

        instruction_i = 32'hE082F003;  // ADD PC,R2,R3
        fetch("addpc_fetch");
        step(1'b0, 1'b1, o(NONE), "addpc_decode");
        step(1'b0, 1'b1, o(NONE), "addpc_exec");
        step(1'b0, 1'b1, o(PCW | PCS | DONE), "addpc_wb");

        instruction_i = 32'hE5910000;  // LDR R0,[R1], ready 3 cycles late
        fetch("ldr_fetch");
        step(1'b0, 1'b1, o(NONE), "ldr_decode");
        step(1'b0, 1'b1, o(ASB), "ldr_addr");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, o(REQ | ADR), "ldr_read_wait");
        step(1'b0, 1'b1, o(REQ | ADR), "ldr_read_ready");
        step(1'b0, 1'b1, o(RW | RS_MEM | DONE), "ldr_wb");

        instruction_i = 32'hE5810000;  // STR R0,[R1]
        fetch("str_fetch");
        step(1'b0, 1'b1, o(NONE), "str_decode");
        step(1'b0, 1'b1, o(ASB), "str_addr");
        step(1'b0, 1'b0, o(REQ | WR | ADR), "str_write_wait");
        step(1'b0, 1'b1, o(REQ | WR | ADR | DONE), "str_write_ready");

        instruction_i = 32'hEB000000;  // BL
        fetch("bl_fetch");
        step(1'b0, 1'b1, o(NONE), "bl_decode");
        step(1'b0, 1'b1, o(PCW | PCS | ASB | RW | LNK | RS_PC | DONE), "bl_branch");

        instruction_i = 32'hEC000000;  // op 11
        step(1'b0, 1'b0, o(REQ), "und_fetch_wait");
        fetch("und_fetch");
        step(1'b0, 1'b1, o(UND | DONE), "und_decode");

        instruction_i = 32'hE0921003;  // ADDS, flags N and V
        nzcv_i = 4'b1001;
        fetch("adds9_fetch");
        step(1'b0, 1'b1, o(NONE), "adds9_decode");
        step(1'b0, 1'b1, o(NONE), "adds9_exec");
        step(1'b0, 1'b1, o(RW | DONE), "adds9_wb");
        ef = 4'b1001;

        instruction_i = 32'hB0821003;  // ADDLT with N==V: skipped
        fetch("lt_fetch");
        step(1'b0, 1'b1, o(DONE), "lt_skip");

        instruction_i = 32'hE5910000;  // LDR interrupted by reset
        fetch("rst_ldr_fetch");
        step(1'b0, 1'b1, o(NONE), "rst_ldr_decode");
        step(1'b0, 1'b1, o(ASB), "rst_ldr_addr");
        step(1'b0, 1'b0, o(REQ | ADR), "rst_ldr_read");
        step(1'b1, 1'b0, NONE, "reset_mid_read");
        ef = 4'b0000;

        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, o(REQ), "timeout_wait");
        step(1'b0, 1'b0, o(TO), "timeout_pulse");
        fetch("post_timeout_fetch");
        step(1'b0, 1'b1, o(NONE), "post_timeout_decode");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
